frame_mode_sequencer: RTL and testbench

Single-clock controller between the board switches, the VGA frame timing and the LeNet core. Debounces the mode switches, applies display-mode changes only at frame boundaries, and sequences each LeNet inference: freeze capture, start the core, wait for done or timeout, hold the result. Outputs gate capture write-enable and select the image fed to the frame buffer.

---
 rtl/frame_mode_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_frame_mode_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_mode_sequencer.sv
// frame_mode_sequencer
// Controller between board switches, VGA frame timing and the LeNet core.
// Debounces the mode switches, applies display-mode changes on frame
// boundaries and sequences one inference per SW7 rise:
// arm -> freeze capture for a frame -> start core -> wait done/timeout -> hold.
//
// Ports:
//   clk25        in   system clock
//   rst          in   synchronous active-high reset
//   sw_raw[3:0]  in   raw switches {SW7 lenet, SW6 pause, SW5 show_resized, SW4 show_cnn}
//   frame_start  in   one-cycle pulse at start of vertical blanking
//   lenet_done   in   one-cycle completion pulse from the core
//   lenet_class  in   core result, valid with lenet_done
//   capture_en   out  capture memory write permit
//   show_resized out  frame-aligned SW5
//   show_cnn     out  frame-aligned SW4
//   lenet_start  out  one-cycle start pulse to the core
//   lenet_busy   out  high while capture is frozen or the core is running
//   result       out  latched class
//   result_valid out  result holds a completed inference
//   timeout      out  sticky, last inference timed out
module frame_mode_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned INFER_TIMEOUT   = 2000000
) (
   input  logic       clk25,
   input  logic       rst,
   input  logic [3:0] sw_raw,
   input  logic       frame_start,
   input  logic       lenet_done,
   input  logic [3:0] lenet_class,
   output logic       capture_en,
   output logic       show_resized,
   output logic       show_cnn,
   output logic       lenet_start,
   output logic       lenet_busy,
   output logic [3:0] result,
   output logic       result_valid,
   output logic       timeout
);

   localparam int unsigned SW_W      = 4;
   localparam int unsigned SW_LENET  = 3;
   localparam int unsigned SW_PAUSE  = 2;
   localparam int unsigned DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned TMR_W     = (INFER_TIMEOUT > 1) ? $clog2(INFER_TIMEOUT) : 1;
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(INFER_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      FREEZE,
      RUN,
      DRAIN,
      SHOW
   } state_t;

   logic [SW_W-1:0]  sync_meta;
   logic [SW_W-1:0]  sync_q;
   logic [SW_W-1:0]  deb;
   logic [DB_W-1:0]  db_cnt [SW_W];
   logic             pause;
   logic             pause_nxt_c;
   logic             lenet_prev;
   logic             lenet_sw;
   state_t           state;
   logic [TMR_W-1:0] timer;

   // Two-flop synchronizer for the asynchronous switches
   always_ff @(posedge clk25) begin
      if (rst) begin
         sync_meta <= '0;
         sync_q    <= '0;
      end else begin
         sync_meta <= sw_raw;
         sync_q    <= sync_meta;
      end
   end

   // Per-bit debounce: accept a change only after it persists for DEBOUNCE_CYCLES edges
   always_ff @(posedge clk25) begin
      if (rst) begin
         deb <= '0;
         for (int i = 0; i < SW_W; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < SW_W; i++) begin
            if (sync_q[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] >= DB_LAST) begin
               deb[i]    <= sync_q[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   assign lenet_sw = deb[SW_LENET];

   // Pause value after this edge; capture_en is registered from it so both move together
   assign pause_nxt_c = frame_start ? deb[SW_PAUSE] : pause;

   // Display modes change only on frame boundaries
   always_ff @(posedge clk25) begin
      if (rst) begin
         pause        <= 1'b0;
         show_resized <= 1'b0;
         show_cnn     <= 1'b0;
      end else if (frame_start) begin
         pause        <= deb[2];
         show_resized <= deb[1];
         show_cnn     <= deb[0];
      end
   end

   // Inference sequencer; busy and capture_en are updated on the same edge as the state
   always_ff @(posedge clk25) begin
      if (rst) begin
         state        <= IDLE;
         timer        <= '0;
         lenet_prev   <= 1'b0;
         lenet_start  <= 1'b0;
         lenet_busy   <= 1'b0;
         capture_en   <= 1'b1;
         result       <= '0;
         result_valid <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         lenet_prev  <= lenet_sw;
         lenet_start <= 1'b0;
         capture_en  <= ~pause_nxt_c & ~lenet_busy;
         case (state)
            IDLE: begin
               if (lenet_sw && !lenet_prev) begin
                  state        <= ARM;
                  timeout      <= 1'b0;
                  result_valid <= 1'b0;
               end
            end
            ARM: begin
               if (!lenet_sw) begin
                  state <= IDLE;
               end else if (frame_start) begin
                  state      <= FREEZE;
                  lenet_busy <= 1'b1;
                  capture_en <= 1'b0;
               end
            end
            FREEZE: begin
               if (!lenet_sw) begin
                  state      <= IDLE;
                  lenet_busy <= 1'b0;
                  capture_en <= ~pause_nxt_c;
               end else if (frame_start) begin
                  state       <= RUN;
                  timer       <= '0;
                  lenet_start <= 1'b1;
               end
            end
            RUN: begin
               timer <= timer + TMR_W'(1);
               // done takes priority over an expiring timer
               if (lenet_done) begin
                  lenet_busy <= 1'b0;
                  capture_en <= ~pause_nxt_c;
                  if (lenet_sw) begin
                     state        <= SHOW;
                     result       <= lenet_class;
                     result_valid <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end else if (timer == TMR_LAST) begin
                  state      <= DRAIN;
                  timeout    <= 1'b1;
                  lenet_busy <= 1'b0;
                  capture_en <= ~pause_nxt_c;
               end
            end
            DRAIN, SHOW: begin
               if (!lenet_sw) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_mode_sequencer.sv
// Bench for frame_mode_sequencer with short debounce and timeout settings.
module tb_frame_mode_sequencer;

   localparam int DEB = 4;
   localparam int TO  = 16;

   localparam int P_IDLE   = 0;
   localparam int P_ARM    = 1;
   localparam int P_FREEZE = 2;
   localparam int P_RUN    = 3;
   localparam int P_DRAIN  = 4;
   localparam int P_SHOW   = 5;

   logic       clk;
   logic       rst;
   logic [3:0] sw_raw;
   logic       frame_start;
   logic       lenet_done;
   logic [3:0] lenet_class;
   logic       capture_en;
   logic       show_resized;
   logic       show_cnn;
   logic       lenet_start;
   logic       lenet_busy;
   logic [3:0] result;
   logic       result_valid;
   logic       timeout;

   int n_checks = 0;
   int n_err    = 0;
   int n_start  = 0;
   bit check_on = 0;

   frame_mode_sequencer #(
      .DEBOUNCE_CYCLES(DEB),
      .INFER_TIMEOUT  (TO)
   ) dut (
      .clk25       (clk),
      .rst         (rst),
      .sw_raw      (sw_raw),
      .frame_start (frame_start),
      .lenet_done  (lenet_done),
      .lenet_class (lenet_class),
      .capture_en  (capture_en),
      .show_resized(show_resized),
      .show_cnn    (show_cnn),
      .lenet_start (lenet_start),
      .lenet_busy  (lenet_busy),
      .result      (result),
      .result_valid(result_valid),
      .timeout     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Switch view: raw seen two edges ago; a bit flips once the synced value
   // has disagreed with the accepted value for DEB edges in a row.
   logic [3:0] m_s1, m_s2, m_deb;
   int         m_mis [4];
   logic       m_prev7, m_pause, m_sr, m_sc;
   int         phase;
   int         m_runcyc;
   logic       m_start, m_rv, m_to;
   logic [3:0] m_res;

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0;
            for (int i = 0; i < 4; i++) m_mis[i] = 0;
            m_prev7 = 0; m_pause = 0; m_sr = 0; m_sc = 0;
            phase = P_IDLE; m_runcyc = 0;
            m_start = 0; m_rv = 0; m_to = 0; m_res = '0;
         end else begin
            logic [3:0] seen, acc;
            logic       on, rise;
            seen = m_s2;
            acc  = m_deb;
            for (int i = 0; i < 4; i++) begin
               if (seen[i] !== acc[i]) begin
                  m_mis[i]++;
                  if (m_mis[i] == DEB) begin
                     m_deb[i] = seen[i];
                     m_mis[i] = 0;
                  end
               end else begin
                  m_mis[i] = 0;
               end
            end
            m_s2 = m_s1;
            m_s1 = sw_raw;
            if (frame_start) begin
               m_pause = acc[2]; m_sr = acc[1]; m_sc = acc[0];
            end
            on      = acc[3];
            rise    = on & ~m_prev7;
            m_prev7 = on;
            m_start = 0;
            if (phase == P_IDLE) begin
               if (rise) begin phase = P_ARM; m_to = 0; m_rv = 0; end
            end else if (phase == P_ARM) begin
               if (!on) phase = P_IDLE;
               else if (frame_start) phase = P_FREEZE;
            end else if (phase == P_FREEZE) begin
               if (!on) phase = P_IDLE;
               else if (frame_start) begin phase = P_RUN; m_start = 1; m_runcyc = 0; end
            end else if (phase == P_RUN) begin
               m_runcyc++;
               if (lenet_done) begin
                  if (on) begin m_res = lenet_class; m_rv = 1; phase = P_SHOW; end
                  else phase = P_IDLE;
               end else if (m_runcyc == TO) begin
                  m_to = 1; phase = P_DRAIN;
               end
            end else begin
               if (!on) phase = P_IDLE;
            end
         end
      end
   end

   // Compare every cycle, away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         if (check_on) begin
            logic busy;
            busy = (phase == P_FREEZE) || (phase == P_RUN);
            chk("m_capture_en",   capture_en,   32'(!m_pause && !busy));
            chk("m_show_resized", show_resized, 32'(m_sr));
            chk("m_show_cnn",     show_cnn,     32'(m_sc));
            chk("m_lenet_start",  lenet_start,  32'(m_start));
            chk("m_lenet_busy",   lenet_busy,   32'(busy));
            chk("m_result",       result,       32'(m_res));
            chk("m_result_valid", result_valid, 32'(m_rv));
            chk("m_timeout",      timeout,      32'(m_to));
         end
         if (lenet_start === 1'b1) n_start++;
      end
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_frame();
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic pulse_done(input logic [3:0] cls);
      lenet_class = cls;
      lenet_done  = 1'b1;
      @(negedge clk);
      lenet_done  = 1'b0;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst = 1'b1; sw_raw = '0; frame_start = 1'b0; lenet_done = 1'b0; lenet_class = '0;
      wait_n(2);
      check_on = 1;
      chk("rst_capture_en", capture_en, 1);
      chk("rst_busy", lenet_busy, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_show_resized", show_resized, 0);
      rst = 1'b0;
      wait_n(2);

      // Debounce: short glitch on SW5 is rejected
      sw_raw[1] = 1'b1; wait_n(1);
      sw_raw[1] = 1'b0; wait_n(1);
      sw_raw[1] = 1'b1; wait_n(1);
      sw_raw[1] = 1'b0; wait_n(6);
      pulse_frame();
      chk("glitch_show_resized", show_resized, 0);
      // Held SW5: not accepted 5 cycles after becoming stable
      sw_raw[1] = 1'b1; wait_n(5);
      pulse_frame();
      chk("deb_early_show_resized", show_resized, 0);
      wait_n(3);
      chk("no_frame_show_resized", show_resized, 0);
      pulse_frame();
      chk("deb_show_resized", show_resized, 1);
      // Held SW4: accepted exactly 6 cycles after becoming stable
      sw_raw[0] = 1'b1; wait_n(6);
      pulse_frame();
      chk("deb_exact_show_cnn", show_cnn, 1);

      // Pause
      sw_raw[2] = 1'b1; wait_n(8);
      chk("pause_before_frame", capture_en, 1);
      pulse_frame();
      chk("pause_capture_off", capture_en, 0);
      sw_raw[2] = 1'b0; wait_n(8);
      pulse_frame();
      chk("unpause_capture_on", capture_en, 1);

      // Inference
      sw_raw[3] = 1'b1; wait_n(8);
      chk("arm_no_start", n_start, 0);
      pulse_frame();
      chk("freeze_capture", capture_en, 0);
      chk("freeze_busy", lenet_busy, 1);
      chk("freeze_no_start", lenet_start, 0);
      wait_n(3);
      pulse_frame();
      chk("run_start", lenet_start, 1);
      wait_n(1);
      chk("run_start_one_cycle", lenet_start, 0);
      wait_n(3);
      pulse_done(4'd7);
      chk("done_result", result, 7);
      chk("done_valid", result_valid, 1);
      chk("done_capture", capture_en, 1);
      chk("one_start", n_start, 1);
      pulse_done(4'd3);
      chk("show_ignores_done", result, 7);
      sw_raw[3] = 1'b0; wait_n(8);
      chk("idle_valid_held", result_valid, 1);

      // Abort from FREEZE
      sw_raw[3] = 1'b1; wait_n(8);
      chk("rearm_valid_clear", result_valid, 0);
      pulse_frame();
      chk("abort_freeze_busy", lenet_busy, 1);
      sw_raw[3] = 1'b0; wait_n(8);
      chk("abort_busy", lenet_busy, 0);
      chk("abort_capture", capture_en, 1);
      pulse_frame();
      wait_n(1);
      chk("abort_no_start", n_start, 1);

      // Timeout
      sw_raw[3] = 1'b1; wait_n(8);
      pulse_frame();
      wait_n(2);
      pulse_frame();
      wait_n(15);
      chk("to_not_yet", timeout, 0);
      chk("to_busy_last", lenet_busy, 1);
      wait_n(1);
      chk("to_set", timeout, 1);
      chk("to_busy_off", lenet_busy, 0);
      chk("to_capture", capture_en, 1);
      pulse_done(4'd5);
      chk("late_done_valid", result_valid, 0);
      chk("late_done_result", result, 7);
      sw_raw[3] = 1'b0; wait_n(8);
      chk("to_sticky", timeout, 1);

      // done in the expiry cycle wins
      sw_raw[3] = 1'b1; wait_n(8);
      chk("arm_clears_timeout", timeout, 0);
      pulse_frame();
      wait_n(2);
      pulse_frame();
      wait_n(15);
      pulse_done(4'd9);
      chk("race_valid", result_valid, 1);
      chk("race_result", result, 9);
      chk("race_timeout", timeout, 0);
      chk("three_starts", n_start, 3);

      // Reset mid-RUN
      sw_raw[3] = 1'b0; wait_n(8);
      sw_raw[3] = 1'b1; wait_n(8);
      pulse_frame();
      wait_n(2);
      pulse_frame();
      wait_n(3);
      chk("pre_rst_busy", lenet_busy, 1);
      rst = 1'b1;
      wait_n(1);
      chk("rst_run_busy", lenet_busy, 0);
      chk("rst_run_capture", capture_en, 1);
      chk("rst_run_valid", result_valid, 0);
      chk("rst_run_result", result, 0);
      chk("rst_run_show_cnn", show_cnn, 0);
      rst = 1'b0;
      wait_n(8);
      pulse_frame();
      chk("restart_busy", lenet_busy, 1);
      wait_n(2);
      pulse_frame();
      chk("restart_start", lenet_start, 1);
      wait_n(2);
      pulse_done(4'd4);
      chk("restart_result", result, 4);
      chk("restart_valid", result_valid, 1);
      wait_n(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
